pipeline_control_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 79 +++++++
 rtl/control_decoder.sv | 65 ++++++
 rtl/pipeline_control_unit.sv | 73 +++++++
 tb/tb_pipeline_control_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode/funct encodings, ALU operations and the packed
// per-instruction control word carried down the pipeline.
package cpu_types_pkg;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = HALT_OPCODE
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    typedef struct packed {
        logic       WEN;
        logic       brnch_eq;
        logic       brnch_ne;
        logic       jmp;
        logic       JR;
        logic       JALflag;
        logic       DRE;
        logic       DWE;
        logic       HALT;
        aluop_t     ALUOP;
        logic       ALUsrc;
        logic       EXTop;
        logic       RegDst;
        logic       MemToReg;
        logic       SHIFTflag;
        logic       LUIflag;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } ctrl_t;

    localparam ctrl_t NOP = '0;

endpackage

// File: rtl/control_decoder.sv
// Pure combinational instruction decode into a ctrl_t, including the
// destination / source register extraction. Shared with the single-cycle core.
module control_decoder
    import cpu_types_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic unused_shamt;
    assign unused_shamt = ^instr_i[10:6];

    always_comb begin
        ctrl_o    = NOP;
        ctrl_o.rs = instr_i[25:21];
        ctrl_o.rt = instr_i[20:16];
        case (instr_i[31:26])
            OP_RTYPE: begin
                ctrl_o.WEN    = 1'b1;
                ctrl_o.RegDst = 1'b1;
                case (instr_i[5:0])
                    FN_SLL:          begin ctrl_o.ALUOP = ALU_SLL; ctrl_o.SHIFTflag = 1'b1; end
                    FN_SRL:          begin ctrl_o.ALUOP = ALU_SRL; ctrl_o.SHIFTflag = 1'b1; end
                    FN_JR:           begin ctrl_o.WEN = 1'b0; ctrl_o.RegDst = 1'b0; ctrl_o.JR = 1'b1; end
                    FN_ADD, FN_ADDU: ctrl_o.ALUOP = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl_o.ALUOP = ALU_SUB;
                    FN_AND:          ctrl_o.ALUOP = ALU_AND;
                    FN_OR:           ctrl_o.ALUOP = ALU_OR;
                    FN_XOR:          ctrl_o.ALUOP = ALU_XOR;
                    FN_NOR:          ctrl_o.ALUOP = ALU_NOR;
                    FN_SLT:          ctrl_o.ALUOP = ALU_SLT;
                    FN_SLTU:         ctrl_o.ALUOP = ALU_SLTU;
                    default:         begin ctrl_o.WEN = 1'b0; ctrl_o.RegDst = 1'b0; end
                endcase
            end
            OP_J:     ctrl_o.jmp = 1'b1;
            OP_JAL:   begin ctrl_o.jmp = 1'b1; ctrl_o.JALflag = 1'b1; ctrl_o.WEN = 1'b1; end
            OP_BEQ:   begin ctrl_o.brnch_eq = 1'b1; ctrl_o.ALUOP = ALU_SUB; ctrl_o.EXTop = 1'b1; end
            OP_BNE:   begin ctrl_o.brnch_ne = 1'b1; ctrl_o.ALUOP = ALU_SUB; ctrl_o.EXTop = 1'b1; end
            OP_ADDI, OP_ADDIU: begin
                ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.EXTop = 1'b1; ctrl_o.ALUOP = ALU_ADD;
            end
            OP_SLTI:  begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.EXTop = 1'b1; ctrl_o.ALUOP = ALU_SLT; end
            OP_SLTIU: begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.EXTop = 1'b1; ctrl_o.ALUOP = ALU_SLTU; end
            OP_ANDI:  begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.ALUOP = ALU_AND; end
            OP_ORI:   begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.ALUOP = ALU_OR; end
            OP_XORI:  begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.ALUOP = ALU_XOR; end
            OP_LUI:   begin ctrl_o.WEN = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.LUIflag = 1'b1; end
            OP_LW: begin
                ctrl_o.WEN = 1'b1; ctrl_o.DRE = 1'b1; ctrl_o.MemToReg = 1'b1;
                ctrl_o.ALUsrc = 1'b1; ctrl_o.EXTop = 1'b1; ctrl_o.ALUOP = ALU_ADD;
            end
            OP_SW:    begin ctrl_o.DWE = 1'b1; ctrl_o.ALUsrc = 1'b1; ctrl_o.EXTop = 1'b1; ctrl_o.ALUOP = ALU_ADD; end
            OP_HALT:  ctrl_o.HALT = 1'b1;
            default:  ;
        endcase

        // dest is zeroed for non-writing words so hazard compares never alias $0
        if (!ctrl_o.WEN)         ctrl_o.dest = 5'd0;
        else if (ctrl_o.JALflag) ctrl_o.dest = 5'd31;
        else if (ctrl_o.RegDst)  ctrl_o.dest = instr_i[15:11];
        else                     ctrl_o.dest = instr_i[20:16];
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control unit: decodes the fetched word and carries control words
// through STAGES registered stages with bubble, freeze and halt handling.
module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned STAGES   = 3,
    parameter bit          LOAD_USE = 1'b1
)(
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [31:0]              instr,
    input  logic                     ihit,
    input  logic                     dhit,
    input  logic                     flush,
    output ctrl_t                    dec_ctrl,
    output ctrl_t [STAGES-1:0]       ctrl_o,
    output logic                     pc_hold,
    output logic                     halt
);

    ctrl_t stage0_in;
    logic  mem_wait, load_use, bubble;
    logic  halt_seen_q, halt_seen_d;
    logic  halt_q, halt_d;

    control_decoder u_dec (
        .instr_i (instr),
        .ctrl_o  (dec_ctrl)
    );

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ctrl_t stage_d, stage_q;
        if (k == 0) begin : g_ex
            always_comb stage_d = mem_wait ? stage_q : stage0_in;
        end else if (k < STAGES - 1) begin : g_mid
            always_comb stage_d = mem_wait ? stage_q : g_stage[k-1].stage_q;
        end else begin : g_wb
            always_comb stage_d = mem_wait ? NOP : g_stage[k-1].stage_q;
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) stage_q <= NOP;
            else       stage_q <= stage_d;
        end

        assign ctrl_o[k] = stage_q;
    end

    always_comb begin
        mem_wait = (g_stage[STAGES-2].stage_q.DRE | g_stage[STAGES-2].stage_q.DWE) & ~dhit;
        load_use = LOAD_USE && g_stage[0].stage_q.DRE && (g_stage[0].stage_q.dest != 5'd0) &&
                   ((g_stage[0].stage_q.dest == dec_ctrl.rs) || (g_stage[0].stage_q.dest == dec_ctrl.rt));
        // flush wins over load_use: both bubble stage 0, so the pending word is simply dropped
        bubble      = flush | load_use | ~ihit | halt_seen_q;
        stage0_in   = bubble ? NOP : dec_ctrl;
        halt_seen_d = halt_seen_q | (~mem_wait & stage0_in.HALT);
        halt_d      = halt_q | g_stage[STAGES-1].stage_d.HALT;
        pc_hold     = mem_wait | load_use | halt_seen_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_seen_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            halt_seen_q <= halt_seen_d;
            halt_q      <= halt_d;
        end
    end

    assign halt = halt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized bench for pipeline_control_unit: three configurations share one
// input stream and are each checked against a list-based pipeline model.
module tb_pipeline_control_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] instr = '0;
    logic        ihit = 1'b0, dhit = 1'b1, flush = 1'b0;

    ctrl_t       dec0, dec1, dec2;
    ctrl_t [2:0] c0;
    ctrl_t [4:0] c1;
    ctrl_t [2:0] c2;
    logic        ph0, ph1, ph2, hl0, hl1, hl2;

    pipeline_control_unit #(.STAGES(3), .LOAD_USE(1'b1)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .flush(flush),
        .dec_ctrl(dec0), .ctrl_o(c0), .pc_hold(ph0), .halt(hl0));
    pipeline_control_unit #(.STAGES(5), .LOAD_USE(1'b1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .flush(flush),
        .dec_ctrl(dec1), .ctrl_o(c1), .pc_hold(ph1), .halt(hl1));
    pipeline_control_unit #(.STAGES(3), .LOAD_USE(1'b0)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .flush(flush),
        .dec_ctrl(dec2), .ctrl_o(c2), .pc_hold(ph2), .halt(hl2));

    always #5 CLK = ~CLK;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    localparam int K_ADDU = 0, K_SUBU = 1, K_OR = 2, K_SLT = 3, K_SLL = 4, K_JR = 5,
                   K_ADDIU = 6, K_ORI = 7, K_SLTI = 8, K_LUI = 9, K_LW = 10, K_SW = 11,
                   K_BEQ = 12, K_BNE = 13, K_J = 14, K_JAL = 15, K_HALT = 16, NK = 17;

    function automatic ctrl_t mk(bit wen, bit beq, bit bne, bit j, bit jr, bit jal, bit dre, bit dwe,
                                 bit hlt, aluop_t op, bit src, bit ext, bit rdst, bit m2r, bit sh, bit lui);
        ctrl_t c = NOP;
        c.WEN = wen; c.brnch_eq = beq; c.brnch_ne = bne; c.jmp = j; c.JR = jr; c.JALflag = jal;
        c.DRE = dre; c.DWE = dwe; c.HALT = hlt; c.ALUOP = op; c.ALUsrc = src; c.EXTop = ext;
        c.RegDst = rdst; c.MemToReg = m2r; c.SHIFTflag = sh; c.LUIflag = lui;
        return c;
    endfunction

    // Instruction-kind table: encoding plus the control flags the ISA assigns it
    function automatic void kinfo(input int k, output logic [5:0] op, output logic [5:0] fn, output ctrl_t b);
        op = 6'h00; fn = 6'h00;
        case (k)
            K_ADDU:  begin fn = 6'h21; b = mk(1,0,0,0,0,0,0,0,0,ALU_ADD, 0,0,1,0,0,0); end
            K_SUBU:  begin fn = 6'h23; b = mk(1,0,0,0,0,0,0,0,0,ALU_SUB, 0,0,1,0,0,0); end
            K_OR:    begin fn = 6'h25; b = mk(1,0,0,0,0,0,0,0,0,ALU_OR,  0,0,1,0,0,0); end
            K_SLT:   begin fn = 6'h2A; b = mk(1,0,0,0,0,0,0,0,0,ALU_SLT, 0,0,1,0,0,0); end
            K_SLL:   begin fn = 6'h00; b = mk(1,0,0,0,0,0,0,0,0,ALU_SLL, 0,0,1,0,1,0); end
            K_JR:    begin fn = 6'h08; b = mk(0,0,0,0,1,0,0,0,0,ALU_ADD, 0,0,0,0,0,0); end
            K_ADDIU: begin op = 6'h09; b = mk(1,0,0,0,0,0,0,0,0,ALU_ADD, 1,1,0,0,0,0); end
            K_ORI:   begin op = 6'h0D; b = mk(1,0,0,0,0,0,0,0,0,ALU_OR,  1,0,0,0,0,0); end
            K_SLTI:  begin op = 6'h0A; b = mk(1,0,0,0,0,0,0,0,0,ALU_SLT, 1,1,0,0,0,0); end
            K_LUI:   begin op = 6'h0F; b = mk(1,0,0,0,0,0,0,0,0,ALU_ADD, 1,0,0,0,0,1); end
            K_LW:    begin op = 6'h23; b = mk(1,0,0,0,0,0,1,0,0,ALU_ADD, 1,1,0,1,0,0); end
            K_SW:    begin op = 6'h2B; b = mk(0,0,0,0,0,0,0,1,0,ALU_ADD, 1,1,0,0,0,0); end
            K_BEQ:   begin op = 6'h04; b = mk(0,1,0,0,0,0,0,0,0,ALU_SUB, 0,1,0,0,0,0); end
            K_BNE:   begin op = 6'h05; b = mk(0,0,1,0,0,0,0,0,0,ALU_SUB, 0,1,0,0,0,0); end
            K_J:     begin op = 6'h02; b = mk(0,0,0,1,0,0,0,0,0,ALU_ADD, 0,0,0,0,0,0); end
            K_JAL:   begin op = 6'h03; b = mk(1,0,0,1,0,1,0,0,0,ALU_ADD, 0,0,0,0,0,0); end
            default: begin op = 6'h3F; b = mk(0,0,0,0,0,0,0,0,1,ALU_ADD, 0,0,0,0,0,0); end
        endcase
    endfunction

    function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm);
        logic [5:0] op, fn;
        ctrl_t b;
        kinfo(k, op, fn, b);
        if (k == K_HALT)   return {op, 26'd0};
        if (op == 6'h00)   return {6'h00, rs, rt, rd, imm[4:0], fn};
        return {op, rs, rt, imm};
    endfunction

    function automatic ctrl_t exp_dec(input int k, input logic [31:0] ins);
        logic [5:0] op, fn;
        ctrl_t c;
        kinfo(k, op, fn, c);
        c.rs = ins[25:21];
        c.rt = ins[20:16];
        if (!c.WEN)         c.dest = 5'd0;
        else if (c.JALflag) c.dest = 5'd31;
        else if (c.RegDst)  c.dest = ins[15:11];
        else                c.dest = ins[20:16];
        return c;
    endfunction

    ctrl_t ms [3][5];
    logic  mhs [3];
    logic  mh  [3];
    logic  lph [3];
    int    S   [3] = '{3, 5, 3};
    logic  LU  [3] = '{1'b1, 1'b1, 1'b0};

    function automatic ctrl_t dut_stage(input int d, input int k);
        case (d)
            0:       return c0[k];
            1:       return c1[k];
            default: return c2[k];
        endcase
    endfunction
    function automatic ctrl_t dut_dec(input int d);
        return (d == 0) ? dec0 : (d == 1) ? dec1 : dec2;
    endfunction
    function automatic logic dut_ph(input int d);
        return (d == 0) ? ph0 : (d == 1) ? ph1 : ph2;
    endfunction
    function automatic logic dut_halt(input int d);
        return (d == 0) ? hl0 : (d == 1) ? hl1 : hl2;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 5; s++) ms[d][s] = NOP;
            mhs[d] = 1'b0;
            mh[d]  = 1'b0;
        end
    endtask

    task automatic check_regs();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < S[d]; s++)
                chk($sformatf("dut%0d ctrl_o[%0d]", d, s), dut_stage(d, s), ms[d][s]);
            chk($sformatf("dut%0d halt", d), dut_halt(d), mh[d]);
        end
    endtask

    task automatic do_cycle(input int k, input logic [31:0] ins, input logic ih, input logic dh, input logic fl);
        ctrl_t ed;
        logic  mw, lu;
        ed = exp_dec(k, ins);
        @(negedge CLK);
        instr = ins; ihit = ih; dhit = dh; flush = fl;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d dec_ctrl", d), dut_dec(d), ed);
            mw = (ms[d][S[d]-2].DRE | ms[d][S[d]-2].DWE) & ~dh;
            lu = LU[d] & ms[d][0].DRE & (ms[d][0].dest != 5'd0) &
                 ((ms[d][0].dest == ed.rs) | (ms[d][0].dest == ed.rt));
            lph[d] = dut_ph(d);
            chk($sformatf("dut%0d pc_hold", d), dut_ph(d), mw | lu | mhs[d]);
            if (mw) begin
                ms[d][S[d]-1] = NOP;
            end else begin
                for (int s = S[d] - 1; s > 0; s--) ms[d][s] = ms[d][s-1];
                ms[d][0] = (fl | lu | ~ih | mhs[d]) ? NOP : ed;
                if (ms[d][0].HALT) mhs[d] = 1'b1;
            end
            if (ms[d][S[d]-1].HALT) mh[d] = 1'b1;
        end
        @(posedge CLK);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check_regs();
        for (int d = 0; d < 3; d++) chk($sformatf("dut%0d pc_hold in reset", d), dut_ph(d), 1'b0);
        @(posedge CLK);
        #1 check_regs();
        #1 nRST = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] addu3, ori4, lw5, addu6, addu7, beq, hlt;
        int          since_halt;
        addu3 = enc(K_ADDU, 5'd1, 5'd2, 5'd3, 16'd0);
        ori4  = enc(K_ORI,  5'd3, 5'd4, 5'd0, 16'd7);
        lw5   = enc(K_LW,   5'd1, 5'd5, 5'd0, 16'd0);
        addu6 = enc(K_ADDU, 5'd5, 5'd2, 5'd6, 16'd0);
        addu7 = enc(K_ADDU, 5'd1, 5'd2, 5'd7, 16'd0);
        beq   = enc(K_BEQ,  5'd1, 5'd2, 5'd0, 16'd4);
        hlt   = enc(K_HALT, 5'd0, 5'd0, 5'd0, 16'd0);
        chk("encode addu", addu3, 32'h0022_1821);
        chk("encode halt", hlt, 32'hFC00_0000);

        // Streaming: ADDU then ORI, no bubbles
        do_reset();
        do_cycle(K_ADDU, addu3, 1'b1, 1'b1, 1'b0);
        chk("addu dec WEN", dec0.WEN, 1'b1);
        chk("addu ex dest", c0[0].dest, 5'd3);
        chk("addu ex rs/rt", {c0[0].rs, c0[0].rt}, {5'd1, 5'd2});
        do_cycle(K_ORI, ori4, 1'b1, 1'b1, 1'b0);
        do_cycle(K_ADDU, addu3, 1'b0, 1'b1, 1'b0);
        chk("addu wb dest", c0[2].dest, 5'd3);
        chk("addu wb WEN", c0[2].WEN, 1'b1);
        chk("ori mem dest", c0[1].dest, 5'd4);
        chk("ihit miss bubble", c0[0], NOP);

        // Load-use: one bubble with LOAD_USE=1, none with LOAD_USE=0
        do_reset();
        do_cycle(K_LW, lw5, 1'b1, 1'b1, 1'b0);
        do_cycle(K_ADDU, addu6, 1'b1, 1'b1, 1'b0);
        chk("load-use pc_hold lu1", lph[0], 1'b1);
        chk("load-use pc_hold lu0", lph[2], 1'b0);
        chk("load-use bubble", c0[0], NOP);
        chk("no bubble lu0", c2[0].dest, 5'd6);
        do_cycle(K_ADDU, addu6, 1'b1, 1'b1, 1'b0);
        chk("load-use released", lph[0], 1'b0);
        chk("load-use addu ex", c0[0].dest, 5'd6);
        chk("load-use lw wb", c0[2].DRE, 1'b1);

        // Memory wait: LW in MEM with dhit=0 for 3 cycles; flush ignored meanwhile
        do_reset();
        do_cycle(K_LW, lw5, 1'b1, 1'b1, 1'b0);
        do_cycle(K_ADDU, addu7, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(K_ORI, ori4, 1'b1, 1'b0, (i == 1));
            chk("mem wait pc_hold", lph[0], 1'b1);
            chk("mem wait wb nop", c0[2], NOP);
            chk("mem wait lw held", c0[1].DRE, 1'b1);
            chk("mem wait ex held", c0[0].dest, 5'd7);
        end
        do_cycle(K_ORI, ori4, 1'b1, 1'b1, 1'b0);
        chk("mem release lw wb", c0[2].DRE, 1'b1);
        chk("mem release ex", c0[0].dest, 5'd4);

        // Flush: wrong-path instruction after BEQ becomes a NOP
        do_reset();
        do_cycle(K_BEQ, beq, 1'b1, 1'b1, 1'b0);
        do_cycle(K_ADDU, addu7, 1'b1, 1'b1, 1'b1);
        chk("flush ex nop", c0[0], NOP);
        chk("flush beq mem", c0[1].brnch_eq, 1'b1);

        // Halt: sticky, halt rises STAGES edges after capture
        do_reset();
        do_cycle(K_HALT, hlt, 1'b1, 1'b1, 1'b0);
        chk("halt in ex", c0[0].HALT, 1'b1);
        for (int e = 2; e <= 8; e++) begin
            do_cycle(K_ADDU, addu3, 1'b1, 1'b1, 1'b0);
            chk("halt pc_hold", lph[0], 1'b1);
            chk("post-halt nop", c0[0], NOP);
            chk("halt S3", hl0, (e >= 3));
            chk("halt S5", hl1, (e >= 5));
        end
        do_reset();

        // Random phase
        since_halt = 0;
        repeat (2500) begin
            int          k, r;
            logic [31:0] ins;
            if (mhs[0] | mhs[1] | mhs[2]) since_halt++;
            if (since_halt > 12 || $urandom_range(0, 149) == 0) begin
                do_reset();
                since_halt = 0;
            end
            r = $urandom_range(0, 99);
            if (r == 0)      k = K_HALT;
            else if (r < 25) k = K_LW;
            else             k = $urandom_range(0, NK - 2);
            ins = enc(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 16'($urandom));
            do_cycle(k, ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 14) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
